// File: rtl/csr_bank.sv
// csr_bank: J1 I/O control/status registers for UART, LED, GPIO banks,
// interval timer and the interrupt line back to the core.
module csr_bank #(
  parameter logic [15:0] BASE       = 16'h0000,
  parameter int          DATA_W     = 16,
  parameter int          GPIO_W     = 8,
  parameter int          GPIO_BANKS = 2,
  parameter int          TIMER_W    = 16,
  parameter int          PRESCALE   = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  j1_mem_addr,
  input  logic [DATA_W-1:0]            j1_dout,
  input  logic                         j1_io_wr,
  input  logic                         j1_io_rd,
  output logic [DATA_W-1:0]            j1_io_din,
  output logic                         uart_tx_wr,
  output logic [7:0]                   uart_tx_wdata,
  input  logic                         uart_tx_tbr_valid,
  output logic                         uart_rx_rd,
  input  logic [7:0]                   uart_rx_rdata,
  input  logic                         uart_rx_d_valid,
  input  logic                         uart_rx_overflow,
  output logic                         uart_rx_clr_ovrflw,
  input  logic [GPIO_BANKS*GPIO_W-1:0] gpio_in,
  output logic [GPIO_BANKS*GPIO_W-1:0] gpio_out,
  output logic [GPIO_BANKS*GPIO_W-1:0] gpio_oe,
  output logic                         led,
  output logic                         irq
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef logic [GPIO_BANKS-1:0][GPIO_W-1:0] gbank_t;

  logic [15:0] ofs;
  assign ofs = j1_mem_addr - BASE;

  logic hit_tx, hit_tbr, hit_rx, hit_rxv, hit_ovf, hit_led;
  logic hit_sum, hit_cnt, hit_cmp, hit_ctrl, hit_stat;

  assign hit_tx   = (ofs == 16'h00);
  assign hit_tbr  = (ofs == 16'h01);
  assign hit_rx   = (ofs == 16'h02);
  assign hit_rxv  = (ofs == 16'h03);
  assign hit_ovf  = (ofs == 16'h04);
  assign hit_led  = (ofs == 16'h05);
  assign hit_sum  = (ofs == 16'h06);
  assign hit_cnt  = (ofs == 16'h08);
  assign hit_cmp  = (ofs == 16'h09);
  assign hit_ctrl = (ofs == 16'h0A);
  assign hit_stat = (ofs == 16'h0B);

  logic [GPIO_BANKS-1:0] hit_in, hit_out, hit_oe, hit_ie, hit_pend;

  for (genvar b = 0; b < GPIO_BANKS; b++) begin : g_dec
    assign hit_in[b]   = (ofs == 16'(16 + 8*b));
    assign hit_out[b]  = (ofs == 16'(16 + 8*b + 1));
    assign hit_oe[b]   = (ofs == 16'(16 + 8*b + 2));
    assign hit_ie[b]   = (ofs == 16'(16 + 8*b + 3));
    assign hit_pend[b] = (ofs == 16'(16 + 8*b + 4));
  end

  logic wr_ovf, wr_led, wr_cnt, wr_cmp, wr_ctrl, wr_stat;

  assign wr_ovf  = j1_io_wr & hit_ovf;
  assign wr_led  = j1_io_wr & hit_led;
  assign wr_cnt  = j1_io_wr & hit_cnt;
  assign wr_cmp  = j1_io_wr & hit_cmp;
  assign wr_ctrl = j1_io_wr & hit_ctrl;
  assign wr_stat = j1_io_wr & hit_stat;

  assign uart_tx_wr    = j1_io_wr & hit_tx;
  assign uart_tx_wdata = j1_dout[7:0];
  assign uart_rx_rd    = j1_io_rd & hit_rx;

  logic [GPIO_W-1:0]  wd_g;
  logic [TIMER_W-1:0] wd_t;

  assign wd_g = j1_dout[GPIO_W-1:0];
  assign wd_t = j1_dout[TIMER_W-1:0];

  // GPIO state
  gbank_t g_out, g_oe, g_ie, g_pend;
  gbank_t s1, s2, s3;
  gbank_t rise, pend_clr;

  assign rise = s2 & ~s3;

  always_comb begin
    pend_clr = '0;
    for (int b = 0; b < GPIO_BANKS; b++) begin
      if (j1_io_wr && hit_pend[b]) pend_clr[b] = wd_g;
    end
  end

  // A new edge overrides a W1C on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      g_out  <= '0;
      g_oe   <= '0;
      g_ie   <= '0;
      g_pend <= '0;
    end else begin
      s1     <= gpio_in;
      s2     <= s1;
      s3     <= s2;
      g_pend <= (g_pend & ~pend_clr) | rise;
      for (int b = 0; b < GPIO_BANKS; b++) begin
        if (j1_io_wr && hit_out[b]) g_out[b] <= wd_g;
        if (j1_io_wr && hit_oe[b])  g_oe[b]  <= wd_g;
        if (j1_io_wr && hit_ie[b])  g_ie[b]  <= wd_g;
      end
    end
  end

  assign gpio_out = g_out;
  assign gpio_oe  = g_oe;

  // Timer
  logic [PS_W-1:0]    psc;
  logic [TIMER_W-1:0] cnt, cmp;
  logic [2:0]         ctrl;
  logic               tpend;
  logic               tick, match;

  assign tick  = ctrl[0] & (psc == PS_MAX);
  assign match = tick & ~wr_cnt & (cnt == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc   <= '0;
      cnt   <= '0;
      cmp   <= '0;
      ctrl  <= '0;
      tpend <= 1'b0;
    end else begin
      if (!ctrl[0])  psc <= '0;
      else if (tick) psc <= '0;
      else           psc <= psc + 1'b1;

      // CPU load beats the tick
      if (wr_cnt)      cnt <= wd_t;
      else if (tick)   cnt <= (match & ctrl[1]) ? '0 : cnt + 1'b1;

      if (wr_cmp)  cmp  <= wd_t;
      if (wr_ctrl) ctrl <= j1_dout[2:0];

      if (match)                   tpend <= 1'b1;
      else if (wr_stat & j1_dout[0]) tpend <= 1'b0;
    end
  end

  // Interrupt summary
  logic [DATA_W-1:0] irq_sum;

  always_comb begin
    irq_sum = '0;
    for (int b = 0; b < GPIO_BANKS; b++) begin
      irq_sum[b] = |(g_pend[b] & g_ie[b]);
    end
    irq_sum[DATA_W-1] = tpend & ctrl[2];
  end

  logic led_r, clr_r, irq_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 1'b0;
      clr_r <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      if (wr_led) led_r <= j1_dout[0];
      clr_r <= wr_ovf & j1_dout[0];
      irq_r <= |irq_sum;
    end
  end

  assign led                = led_r;
  assign uart_rx_clr_ovrflw = clr_r;
  assign irq                = irq_r;

  // Read mux
  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = DATA_W'(16'hBADA);
    unique case (1'b1)
      hit_tbr:  rdata = DATA_W'(uart_tx_tbr_valid);
      hit_rx:   rdata = DATA_W'(uart_rx_rdata);
      hit_rxv:  rdata = DATA_W'(uart_rx_d_valid);
      hit_ovf:  rdata = DATA_W'(uart_rx_overflow);
      hit_led:  rdata = DATA_W'(led_r);
      hit_sum:  rdata = irq_sum;
      hit_cnt:  rdata = DATA_W'(cnt);
      hit_cmp:  rdata = DATA_W'(cmp);
      hit_ctrl: rdata = DATA_W'(ctrl);
      hit_stat: rdata = DATA_W'(tpend);
      default: begin
        for (int b = 0; b < GPIO_BANKS; b++) begin
          if (hit_in[b])   rdata = DATA_W'(s2[b]);
          if (hit_out[b])  rdata = DATA_W'(g_out[b]);
          if (hit_oe[b])   rdata = DATA_W'(g_oe[b]);
          if (hit_ie[b])   rdata = DATA_W'(g_ie[b]);
          if (hit_pend[b]) rdata = DATA_W'(g_pend[b]);
        end
      end
    endcase
    if (!j1_io_rd) rdata = DATA_W'(16'hDEAD);
  end

  assign j1_io_din = rdata;

endmodule
